// File: rtl/if_fetch.sv
// Instruction fetch unit: direct-mapped one-word icache in front of a byte-wide memory port.
// A miss assembles the word little-endian from four sequential byte reads and refills the line.
module if_fetch #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned LINES  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [31:0]       pc,
    input  logic              if_inst_re,
    input  logic              flush,
    input  logic              mem_busy,
    input  logic [7:0]        mem_din,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_re,
    output logic [31:0]       inst,
    output logic [31:0]       inst_pc,
    output logic              inst_valid,
    output logic              stall_req
);

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StLookup = 3'd1;
    localparam logic [2:0] StIssue  = 3'd2;
    localparam logic [2:0] StDrain  = 3'd3;
    localparam logic [2:0] StDone   = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic [1:0]  pend_idx_q, pend_idx_d;
    logic [31:0] asm_q, asm_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        inst_valid_q, inst_valid_d;
    logic        stall_q, stall_d;

    logic [LINES-1:0] line_valid_q;
    logic [TAG_W-1:0] line_tag_q  [LINES];
    logic [31:0]      line_data_q [LINES];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] req_tag;
    logic             hit;
    logic             line_we;
    logic [31:0]      asm_merged;

    assign idx     = req_pc_q[IDX_W+1:2];
    assign req_tag = req_pc_q[ADDR_W-1:IDX_W+2];
    assign hit     = line_valid_q[idx] && (line_tag_q[idx] == req_tag);

    assign mem_re = (state_q == StIssue) && rdy && !flush && !mem_busy;
    assign mem_a  = (state_q == StIssue)
                  ? req_pc_q[ADDR_W-1:0] + {{(ADDR_W-2){1'b0}}, cnt_q}
                  : '0;

    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_valid = inst_valid_q;
    assign stall_req  = stall_q;

    // The byte issued last cycle is on mem_din now; fold it in regardless of rdy so it is not lost.
    always_comb begin
        asm_merged = asm_q;
        if (pend_q) begin
            asm_merged[{pend_idx_q, 3'b000} +: 8] = mem_din;
        end
    end

    always_comb begin
        state_d      = state_q;
        req_pc_d     = req_pc_q;
        cnt_d        = cnt_q;
        pend_d       = 1'b0;
        pend_idx_d   = pend_idx_q;
        asm_d        = asm_merged;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        stall_d      = stall_q;
        line_we      = 1'b0;

        if (!rdy) begin
            // Frozen: everything holds; only the in-flight byte is absorbed above.
            state_d = state_q;
        end else if (flush) begin
            state_d      = StIdle;
            cnt_d        = 2'd0;
            asm_d        = asm_q;
            inst_valid_d = 1'b0;
            stall_d      = 1'b0;
        end else begin
            inst_valid_d = 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (if_inst_re) begin
                        req_pc_d = pc;
                        stall_d  = 1'b1;
                        state_d  = StLookup;
                    end
                end
                StLookup: begin
                    if (hit) begin
                        inst_d       = line_data_q[idx];
                        inst_pc_d    = req_pc_q;
                        inst_valid_d = 1'b1;
                        stall_d      = 1'b0;
                        state_d      = StIdle;
                    end else begin
                        cnt_d   = 2'd0;
                        state_d = StIssue;
                    end
                end
                StIssue: begin
                    if (!mem_busy) begin
                        pend_d     = 1'b1;
                        pend_idx_d = cnt_q;
                        cnt_d      = cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state_d = StDrain;
                        end
                    end
                end
                StDrain: begin
                    line_we      = 1'b1;
                    inst_d       = asm_merged;
                    inst_pc_d    = req_pc_q;
                    inst_valid_d = 1'b1;
                    stall_d      = 1'b0;
                    state_d      = StDone;
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            req_pc_q     <= '0;
            cnt_q        <= '0;
            pend_q       <= 1'b0;
            pend_idx_q   <= '0;
            asm_q        <= '0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
            stall_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_pc_q     <= req_pc_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            pend_idx_q   <= pend_idx_d;
            asm_q        <= asm_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            stall_q      <= stall_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_valid_q <= '0;
        end else if (line_we) begin
            line_valid_q[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) begin
            line_tag_q[idx]  <= req_tag;
            line_data_q[idx] <= asm_merged;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: transaction-level cache/memory model plus a per-cycle compare process.
module tb_if_fetch;

    localparam int ADDR_W = 17;
    localparam int LINES  = 16;
    localparam int IDX_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              rdy;
    logic [31:0]       pc;
    logic              if_inst_re;
    logic              flush;
    logic              mem_busy;
    logic [7:0]        mem_din;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_re;
    logic [31:0]       inst;
    logic [31:0]       inst_pc;
    logic              inst_valid;
    logic              stall_req;

    if_fetch #(
        .ADDR_W(ADDR_W),
        .LINES (LINES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .pc        (pc),
        .if_inst_re(if_inst_re),
        .flush     (flush),
        .mem_busy  (mem_busy),
        .mem_din   (mem_din),
        .mem_a     (mem_a),
        .mem_re    (mem_re),
        .inst      (inst),
        .inst_pc   (inst_pc),
        .inst_valid(inst_valid),
        .stall_req (stall_req)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Memory image: explicit bytes where the test needs them, a fixed hash elsewhere.
    logic [7:0] mem_img [int unsigned];

    function automatic logic [7:0] mem_byte(input int unsigned a);
        if (mem_img.exists(a)) return mem_img[a];
        return 8'((a * 37 + 11) & 255);
    endfunction

    always @(posedge clk) mem_din <= mem_re ? mem_byte({15'd0, mem_a}) : 8'h5a;

    // Reference cache model.
    bit          mvalid [LINES];
    int unsigned mtag   [LINES];
    logic [31:0] mdata  [LINES];

    // Expectations consumed by the compare process.
    int          exp_vcyc = -1;
    logic [31:0] exp_inst;
    logic [31:0] exp_pc;
    int          st_lo = 1;
    int          st_hi = 0;
    int unsigned exp_addr_q [$];
    bit          chk_en = 1'b0;
    int          n_issue = 0;
    int          last_vcyc = -100;
    logic [31:0] last_inst;

    always @(negedge clk) begin
        if (chk_en) begin
            chk(inst_valid == (cyc == exp_vcyc), "inst_valid", {31'd0, inst_valid},
                {31'd0, cyc == exp_vcyc});
            if (cyc == exp_vcyc) begin
                chk(inst == exp_inst, "inst", inst, exp_inst);
                chk(inst_pc == exp_pc, "inst_pc", inst_pc, exp_pc);
            end
            if (inst_valid) begin
                last_vcyc = cyc;
                last_inst = inst;
            end
            chk(stall_req == (cyc >= st_lo && cyc <= st_hi), "stall_req", {31'd0, stall_req},
                {31'd0, cyc >= st_lo && cyc <= st_hi});
            if (mem_re) begin
                n_issue++;
                if (exp_addr_q.size() == 0) begin
                    chk(1'b0, "unexpected_mem_re", {15'd0, mem_a}, 32'd0);
                end else begin
                    chk({15'd0, mem_a} == exp_addr_q[0], "mem_a", {15'd0, mem_a},
                        exp_addr_q[0]);
                    void'(exp_addr_q.pop_front());
                end
                chk(!mem_busy, "mem_re_while_busy", {31'd0, mem_re}, 32'd0);
            end
            if (!rdy) chk(!mem_re, "mem_re_while_not_rdy", {31'd0, mem_re}, 32'd0);
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // mode 0: normal, 1: flush during ISSUE cnt=1, 2: reset during DRAIN.
    task automatic fetch(input logic [31:0] a, input int busy_len, input int mode,
                         output int lat, output int issues);
        int unsigned am, ix, tg;
        logic [31:0] word;
        bit          hit;
        int          r, n0;
        @(posedge clk);
        #1;
        am   = a & ((32'd1 << ADDR_W) - 1);
        ix   = (am >> 2) % LINES;
        tg   = am >> (IDX_W + 2);
        word = {mem_byte(am + 3), mem_byte(am + 2), mem_byte(am + 1), mem_byte(am)};
        hit  = mvalid[ix] && (mtag[ix] == tg);
        r    = cyc + 1;
        n0   = n_issue;
        last_vcyc = -100;
        exp_pc   = a;
        exp_inst = hit ? mdata[ix] : word;
        st_lo    = r;
        if (hit) begin
            st_hi    = r;
            exp_vcyc = r + 1;
        end else begin
            for (int k = 0; k < 4; k++) exp_addr_q.push_back(am + k);
            st_hi    = r + 5 + busy_len;
            exp_vcyc = r + 6 + busy_len;
        end
        if (mode == 1) begin
            st_hi    = r + 2;
            exp_vcyc = -1;
        end else if (mode == 2) begin
            st_hi    = r + 5;
            exp_vcyc = -1;
        end
        pc         = a;
        if_inst_re = 1'b1;
        @(posedge clk);
        #1;
        if_inst_re = 1'b0;
        pc         = 32'hdead_beec;
        if (busy_len > 0) begin
            wait_cyc(r + 3);
            mem_busy = 1'b1;
            wait_cyc(r + 3 + busy_len);
            mem_busy = 1'b0;
        end
        if (mode == 1) begin
            wait_cyc(r + 2);
            flush      = 1'b1;
            if_inst_re = 1'b1;
            pc         = 32'h0000_0200;
            wait_cyc(r + 3);
            flush      = 1'b0;
            if_inst_re = 1'b0;
            exp_addr_q.delete();
            wait_cyc(r + 6);
        end else if (mode == 2) begin
            wait_cyc(r + 5);
            rst = 1'b1;
            wait_cyc(r + 6);
            rst = 1'b0;
            chk(inst == 32'd0, "reset_inst", inst, 32'd0);
            chk(inst_pc == 32'd0, "reset_inst_pc", inst_pc, 32'd0);
            chk({15'd0, mem_a} == 32'd0, "reset_mem_a", {15'd0, mem_a}, 32'd0);
            for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
            wait_cyc(r + 8);
        end else begin
            wait_cyc(r + 9 + busy_len);
            chk(exp_addr_q.size() == 0, "byte_reads_missing", exp_addr_q.size(), 32'd0);
            if (!hit) begin
                mvalid[ix] = 1'b1;
                mtag[ix]   = tg;
                mdata[ix]  = word;
            end
        end
        lat    = (last_vcyc < 0) ? -1 : last_vcyc - r + 1;
        issues = n_issue - n0;
    endtask

    int lat, iss;

    initial begin
        rst = 1'b1; rdy = 1'b1; pc = '0; if_inst_re = 1'b0; flush = 1'b0; mem_busy = 1'b0;
        for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
        mem_img[4] = 8'h13; mem_img[5] = 8'h05; mem_img[6] = 8'h10; mem_img[7] = 8'h00;
        mem_img[0] = 8'h93; mem_img[1] = 8'h00; mem_img[2] = 8'h10; mem_img[3] = 8'h00;
        mem_img[32'h40] = 8'h6f; mem_img[32'h41] = 8'h00; mem_img[32'h42] = 8'h00;
        mem_img[32'h43] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk(inst_valid == 1'b0, "rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk(stall_req == 1'b0, "rst_stall_req", {31'd0, stall_req}, 32'd0);
        chk(mem_re == 1'b0, "rst_mem_re", {31'd0, mem_re}, 32'd0);
        chk(mem_a == '0, "rst_mem_a", {15'd0, mem_a}, 32'd0);
        chk(inst == 32'd0, "rst_inst", inst, 32'd0);
        chk(inst_pc == 32'd0, "rst_inst_pc", inst_pc, 32'd0);
        chk_en = 1'b1;

        fetch(32'h0000_0004, 0, 0, lat, iss);
        chk(lat == 7, "cold_miss_latency", lat, 32'd7);
        chk(iss == 4, "cold_miss_reads", iss, 32'd4);
        chk(last_inst == 32'h0010_0513, "cold_miss_inst", last_inst, 32'h0010_0513);

        fetch(32'h0000_0004, 0, 0, lat, iss);
        chk(lat == 2, "hit_latency", lat, 32'd2);
        chk(iss == 0, "hit_reads", iss, 32'd0);
        chk(last_inst == 32'h0010_0513, "hit_inst", last_inst, 32'h0010_0513);

        fetch(32'h8002_0004, 0, 0, lat, iss);
        chk(iss == 0, "alias_hit_reads", iss, 32'd0);

        fetch(32'h0000_0008, 3, 0, lat, iss);
        chk(lat == 10, "busy_latency", lat, 32'd10);
        chk(iss == 4, "busy_reads", iss, 32'd4);

        fetch(32'h0000_0000, 0, 0, lat, iss);
        chk(last_inst == 32'h0010_0093, "line0_inst", last_inst, 32'h0010_0093);
        fetch(32'h0000_0040, 0, 0, lat, iss);
        chk(iss == 4, "conflict_miss_reads", iss, 32'd4);
        chk(last_inst == 32'h0000_006f, "conflict_inst", last_inst, 32'h0000_006f);
        fetch(32'h0000_0000, 0, 0, lat, iss);
        chk(iss == 4, "conflict_refetch_reads", iss, 32'd4);

        fetch(32'hffff_fffc, 0, 0, lat, iss);
        chk(iss == 4, "wrap_reads", iss, 32'd4);

        @(posedge clk);
        #1;
        rdy = 1'b0; if_inst_re = 1'b1; pc = 32'h0000_0004;
        repeat (3) @(posedge clk);
        #1;
        chk(stall_req == 1'b0, "rdy_low_no_accept", {31'd0, stall_req}, 32'd0);
        rdy = 1'b1; if_inst_re = 1'b0;

        fetch(32'h0000_000c, 0, 1, lat, iss);
        chk(lat == -1, "flush_no_valid", lat, 32'hffff_ffff);
        fetch(32'h0000_000c, 0, 0, lat, iss);
        chk(iss == 4, "after_flush_reads", iss, 32'd4);
        chk(lat == 7, "after_flush_latency", lat, 32'd7);

        fetch(32'h0000_0010, 0, 2, lat, iss);
        chk(lat == -1, "reset_drain_no_valid", lat, 32'hffff_ffff);
        fetch(32'h0000_0010, 0, 0, lat, iss);
        chk(iss == 4, "after_reset_reads", iss, 32'd4);
        fetch(32'h0000_0004, 0, 0, lat, iss);
        chk(iss == 4, "after_reset_cold_reads", iss, 32'd4);
        chk(last_inst == 32'h0010_0513, "after_reset_inst", last_inst, 32'h0010_0513);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter ADDR_W, default 17: width of the byte address on the memory bus.
REQ-002 Parameter LINES, default 16: number of direct-mapped one-word icache lines, power of 2.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 rdy  in  1  global ready; when low, all state holds and mem_re=0.
REQ-006 pc  in  32  fetch address from PC stage, word aligned.
REQ-007 if_inst_re  in  1  fetch request, sampled with pc.
REQ-008 flush  in  1  branch redirect; aborts the in-flight fetch.
REQ-009 mem_busy  in  1  memory port owned by data side; no byte read may issue.
REQ-010 mem_din  in  8  read byte, valid the cycle after its address was issued.
REQ-011 mem_a  out  ADDR_W  byte address to memory.
REQ-012 mem_re  out  1  byte read strobe.
REQ-013 inst  out  32  fetched instruction, little-endian assembled.
REQ-014 inst_pc  out  32  pc of inst.
REQ-015 inst_valid  out  1  one-cycle pulse: inst/inst_pc valid.
REQ-016 stall_req  out  1  fetch in progress; the PC stage must hold.

Function
REQ-017 States: IDLE, LOOKUP, ISSUE, DRAIN, DONE.
REQ-018 IDLE: if_inst_re=1 and rdy=1 -> latch pc into req_pc, go LOOKUP; stall_req=1 from the next cycle.
REQ-019 Cache index = req_pc[log2(LINES)+1:2]; tag = req_pc[ADDR_W-1:log2(LINES)+2]; line = valid bit, tag, 32-bit data.
REQ-020 LOOKUP hit: inst=line data, inst_pc=req_pc, inst_valid=1 on the next cycle; go IDLE; total latency 2 cycles from the request edge.
REQ-021 LOOKUP miss: byte counter cnt=0, go ISSUE.
REQ-022 ISSUE: when mem_busy=0, mem_re=1 and mem_a=req_pc[ADDR_W-1:0]+cnt, then cnt increments; when mem_busy=1, mem_re=0 and cnt holds.
REQ-023 The byte returned for issue k is written into bits [8k+7:8k] of the assembly register.
REQ-024 After issue of cnt=3, go DRAIN; DRAIN captures byte 3, writes the line (valid=1, tag, data), and goes DONE.
REQ-025 DONE: inst_valid=1 for exactly one cycle, with inst=assembled word and inst_pc=req_pc; stall_req=0; go IDLE.
REQ-026 Miss latency with mem_busy=0 throughout: inst_valid rises 7 cycles after the request edge.
REQ-027 stall_req=1 in LOOKUP-miss, ISSUE, and DRAIN; 0 in IDLE and DONE.
REQ-028 A mem_busy stall suspends issue only; a byte issued in the prior cycle is still captured.
REQ-029 flush=1 in any state: go IDLE next cycle; inst_valid=0; stall_req=0; no line write.
REQ-030 A byte in flight at the time of a flush is discarded.
REQ-031 A request during a flush cycle is ignored.
REQ-032 rdy=0 freezes state, counter, and outputs, except that mem_re is forced to 0.
REQ-033 Address arithmetic is modulo 2^ADDR_W; pc bits above ADDR_W are ignored for tag and address but are returned unchanged in inst_pc.

Reset
REQ-034 rst=1 at an edge: state=IDLE, all line valid bits=0, cnt=0, inst=0, inst_pc=0, inst_valid=0, stall_req=0, mem_re=0, mem_a=0.
REQ-035 Reset overrides flush, rdy, and any in-progress fetch.
REQ-036 Cache contents after reset are invalid, so the first fetch of any address misses.

Verification
REQ-037 Cold miss: after reset, pc=0x00000004 requested; memory bytes 4..7 = 13,05,10,00 -> mem_a sequence 4,5,6,7; inst=0x00100513 with inst_valid 7 cycles after the request.
REQ-038 Hit: same pc requested again -> no mem_re; inst=0x00100513 two cycles after the request edge.
REQ-039 mem_busy held high for 3 cycles during ISSUE of cnt=2 -> issue resumes at the same address; inst is correct; latency is 10 cycles.
REQ-040 Conflict: pc=0x40 after pc=0x00 (same index, LINES=16) -> miss, the line is replaced, and a later fetch of 0x00 misses again.
REQ-041 flush during ISSUE cnt=1 -> IDLE next cycle, no inst_valid, line stays invalid; a subsequent request refetches all 4 bytes.
REQ-042 rst asserted mid-DRAIN -> all outputs are 0 next cycle; a re-fetch of the same pc misses.
